// File: rtl/sram_access_sequencer.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases, low half first.
// Optional macro SRAM_STALL_CNT_EN adds a saturating count of clock edges seen with ready low.
module sram_access_sequencer #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] sramData,
  output logic [17:0] sramAddress,
  output logic [4:0]  sramCtrl
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [31:0] stallCount
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST     = 4'(ACCESS_CYCLES - 1);
  // {WE_N, CE_N, OE_N, LB_N, UB_N}
  localparam logic [4:0] CTRL_OFF = 5'b11111;
  localparam logic [4:0] CTRL_RD  = 5'b10000;
  localparam logic [4:0] CTRL_WR  = 5'b00100;

  state_t      state;
  logic [3:0]  cnt;
  logic        is_wr;
  logic [16:0] word;
  logic [15:0] wdata_hi;
  logic        drv;
  logic [15:0] dout;
  logic        req;
  logic [16:0] word_in;

  assign req     = wrEn | rdEn;
  // Offset bits [1:0] and [31:19] are dropped, so addresses past the SRAM wrap.
  assign word_in = 17'((address - BASE_ADDR) >> 2);

  assign ready    = ((state == IDLE) && !req) || (state == DONE);
  assign sramData = drv ? dout : 16'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      is_wr       <= 1'b0;
      word        <= 17'd0;
      wdata_hi    <= 16'd0;
      drv         <= 1'b0;
      dout        <= 16'd0;
      readData    <= 32'd0;
      sramAddress <= 18'd0;
      sramCtrl    <= CTRL_OFF;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Write has priority when both requests are raised together.
            is_wr       <= wrEn;
            word        <= word_in;
            wdata_hi    <= writeData[31:16];
            cnt         <= 4'd0;
            state       <= LO;
            sramAddress <= {word_in, 1'b0};
            sramCtrl    <= wrEn ? CTRL_WR : CTRL_RD;
            drv         <= wrEn;
            dout        <= writeData[15:0];
          end
        end
        LO: begin
          if (cnt == LAST) begin
            cnt         <= 4'd0;
            state       <= HI;
            sramAddress <= {word, 1'b1};
            dout        <= wdata_hi;
            if (!is_wr) readData[15:0] <= sramData;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (cnt == LAST) begin
            cnt      <= 4'd0;
            state    <= DONE;
            sramCtrl <= CTRL_OFF;
            drv      <= 1'b0;
            if (!is_wr) readData[31:16] <= sramData;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount <= 32'd0;
    end else if (!ready && (stallCount != 32'hFFFF_FFFF)) begin
      stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Randomized scoreboard bench for sram_access_sequencer with a behavioural SRAM and reference memory.
module tb_sram_access_sequencer;

  localparam int          AC   = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] address, writeData;
  logic [31:0] readData;
  logic        ready;
  wire  [15:0] sramData;
  logic [17:0] sramAddress;
  logic [4:0]  sramCtrl;
`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stallCount;
`endif

  sram_access_sequencer #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready), .sramData(sramData),
    .sramAddress(sramAddress), .sramCtrl(sramCtrl)
`ifdef SRAM_STALL_CNT_EN
    , .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_acc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Behavioural SRAM: drives the bus on a read, captures on any edge with WE_N and CE_N low.
  logic [15:0] sram_mem [0:262143];
  assign sramData = (sramCtrl[4] && !sramCtrl[3] && !sramCtrl[2]) ? sram_mem[sramAddress] : 16'bz;
  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    forever begin
      @(posedge clk);
      if (!sramCtrl[4] && !sramCtrl[3]) sram_mem[sramAddress] = sramData;
    end
  end

  // Reference model: half-word memory and last load result.
  typedef struct {
    logic [31:0] rd;
    int          low;
    int          we;
    logic [17:0] lo_a;
    logic [17:0] hi_a;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] ref_mem [int];
  logic [31:0] ref_rd = 32'h0;

  function automatic logic [15:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   word;
    word      = int'(((a - BASE) >> 2) & 32'h1FFFF);
    wrEn      = w;
    rdEn      = r;
    address   = a;
    writeData = d;
    e.lo_a = 18'(word * 2);
    e.hi_a = 18'(word * 2 + 1);
    e.low  = 2 * AC + 1;
    if (w) begin
      ref_mem[word * 2]     = d[15:0];
      ref_mem[word * 2 + 1] = d[31:16];
      e.we = 2 * AC;
    end else begin
      ref_rd = {ref_get(word * 2 + 1), ref_get(word * 2)};
      e.we   = 0;
    end
    e.rd = ref_rd;
    n_acc++;
    exp_q.push_back(e);
  endtask

  // Lets the access run to DONE while scrambling inputs that must be ignored.
  task automatic run_access(input bit from_done);
    int n;
    repeat (from_done ? 2 : 1) begin @(posedge clk); #1; end
    n = 0;
    while (!ready && n < 50) begin
      {wrEn, rdEn} = 2'($urandom);
      address      = $urandom;
      writeData    = $urandom;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: ready still %0b after %0d cycles", ready, n);
    end
  endtask

  task automatic go_idle();
    wrEn = 1'b0;
    rdEn = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: accumulates per-access observations, compares when ready returns high.
  int          low_cnt = 0, we_cnt = 0;
  bit          seen_lo = 0;
  logic [17:0] lo_addr, hi_addr;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      low_cnt = 0; we_cnt = 0; seen_lo = 0;
    end else begin
      if (!ready) low_cnt++;
      if (!sramCtrl[4]) we_cnt++;
      if (!sramCtrl[3]) begin
        if (!seen_lo) begin lo_addr = sramAddress; seen_lo = 1; end
        hi_addr = sramAddress;
      end
      if (ready && low_cnt > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got access with %0d low cycles, required none", low_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("readData", readData, e.rd);
          chk("ready_low_cycles", low_cnt, e.low);
          chk("we_low_cycles", we_cnt, e.we);
          chk("lo_addr", lo_addr, e.lo_a);
          chk("hi_addr", hi_addr, e.hi_a);
        end
        low_cnt = 0; we_cnt = 0; seen_lo = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b0; wrEn = 1'b0; rdEn = 1'b0; address = 32'h0; writeData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", sramCtrl, 5'b11111);
    chk("rst_readData", readData, 32'h0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_addr", sramAddress, 18'h0);
`ifdef SRAM_STALL_CNT_EN
    chk("rst_stall", stallCount, 32'h0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 32'd1032, 32'hDEADBEEF);
    run_access(0);
    chk("store_hw4", sram_mem[4], 16'hBEEF);
    chk("store_hw5", sram_mem[5], 16'hDEAD);
    issue(0, 1, 32'd1032, 32'h0);
    run_access(1);
    chk("load_ready", ready, 1'b1);
    chk("load_data", readData, 32'hDEADBEEF);

    go_idle();
    issue(1, 1, 32'd1024, 32'h12345678);
    run_access(0);
    chk("both_hw0", sram_mem[0], 16'h5678);
    chk("both_hw1", sram_mem[1], 16'h1234);

    go_idle();
    c0 = cyc;
    issue(1, 0, 32'd1040, 32'hCAFEF00D);
    run_access(0);
    issue(0, 1, 32'd1040, 32'h0);
    run_access(1);
    chk("pair_cycles", cyc - c0 + 1, 12);

    for (int t = 0; t < 40; t++) begin
      bit          b2b;
      int          op;
      logic [31:0] a;
      b2b = 1'($urandom_range(0, 1));
      op  = $urandom_range(0, 3);
      a   = BASE + ($urandom_range(0, 3) << 19) + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      if (!b2b) begin
        wrEn = 1'b0; rdEn = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      issue(op <= 1, op != 1, a, $urandom);
      run_access(b2b);
    end

    go_idle();
    chk("queue_drained", exp_q.size(), 0);
`ifdef SRAM_STALL_CNT_EN
    chk("stall_total", stallCount, n_acc * (2 * AC + 1));
`endif

    // Abort a load during its high phase.
    rdEn = 1'b1; wrEn = 1'b0; address = 32'd1032;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_in_hi", {sramAddress[0], sramCtrl}, {1'b1, 5'b10000});
    rst = 1'b0; rdEn = 1'b0;
    #1;
    ref_rd = 32'h0;
    chk("abort_ctrl", sramCtrl, 5'b11111);
    chk("abort_readData", readData, 32'h0);
    chk("abort_ready", ready, 1'b1);
`ifdef SRAM_STALL_CNT_EN
    chk("abort_stall", stallCount, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(0, 1, 32'd1032, 32'h0);
    run_access(0);
`ifdef SRAM_STALL_CNT_EN
    chk("stall_after_reset", stallCount, 32'd5);
`endif
    go_idle();
    go_idle();
    chk("final_queue", exp_q.size(), 0);
    foreach (ref_mem[k]) chk("sram_contents", sram_mem[k], ref_mem[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
Sequences 32-bit MEM-stage loads/stores from the ARM pipeline onto the 16-bit external SRAM bus as two half-word accesses (low half first). Sits between the MEM stage and the SRAM model. Drives the SRAM address, data and control pins, and returns `ready`; the pipeline freezes while `ready` is low.

Parameters:
- BASE_ADDR, 1024: CPU byte address mapped to SRAM word 0.
- ACCESS_CYCLES, 2: cycles each half-word phase holds address and controls; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wrEn  input  1  store request from MEM stage.
- rdEn  input  1  load request from MEM stage.
- address  input  32  CPU byte address.
- writeData  input  32  store data.
- readData  output  32  load result, valid while `ready`=1 after a load.
- ready  output  1  0 = access in progress, pipeline must freeze.
- sramData  inout  16  SRAM data bus.
- sramAddress  output  18  SRAM half-word address.
- sramCtrl  output  5  {WE_N, CE_N, OE_N, LB_N, UB_N}; all active-low.

Behaviour:
- Address mapping:
  - off = address − BASE_ADDR (32-bit wrap).
  - word = off[18:2].
  - Low phase: sramAddress = {word, 1'b0}. High phase: sramAddress = {word, 1'b1}.
  - off[1:0] and off[31:19] are ignored, so higher addresses wrap.
- States: IDLE, LO, HI, DONE. A phase counter counts 0..ACCESS_CYCLES−1.
- IDLE:
  - If wrEn|rdEn, capture op, word and writeData, then go to LO with counter = 0.
  - If both are asserted, the write wins.
  - If no request, stay in IDLE.
- LO:
  - Counter increments each cycle; on reaching ACCESS_CYCLES−1, go to HI with counter = 0.
  - On a read, sample sramData into readData[15:0] on that last cycle.
- HI: same as LO; reads sample into readData[31:16]; go to DONE.
- DONE: one cycle, then IDLE.
- ready: combinational, ready = (state==IDLE && !(wrEn|rdEn)) || state==DONE. Load-to-ready latency is 2·ACCESS_CYCLES+1 cycles with `ready` low; the same applies to stores.
- Request inputs are ignored outside IDLE; captured values are used for the whole access.
- A request still asserted in the IDLE cycle after DONE starts a new access. This covers back-to-back memory ops.
- sramCtrl:
  - IDLE/DONE: 5'b11111.
  - LO/HI read: WE_N=1, CE_N=0, OE_N=0, LB_N=0, UB_N=0.
  - LO/HI write: WE_N=0, CE_N=0, OE_N=1, LB_N=0, UB_N=0.
- sramData:
  - Driven only in LO/HI of a write: writeData[15:0] in LO, writeData[31:16] in HI.
  - High-Z otherwise.
- readData is a register. It holds its last value until the next load overwrites it; stores do not change it.
- Reset (async, rst=0):
  - state=IDLE, counter=0, readData=0, sramAddress=0, sramCtrl=5'b11111, sramData=Z.
  - ready follows its combinational rule.
  - Reset asserted mid-access aborts the access; no partial readData update survives.

Optional Feature:
SRAM_STALL_CNT_EN
- Defined:
  - Adds output `stallCount` (32 bits, reset 0).
  - Increments on every clock edge where ready=0.
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 with wrEn=rdEn=0 → sramCtrl=5'b11111, sramData=Z, readData=0, ready=1.
- Store, ACCESS_CYCLES=2: wrEn=1, address=1032, writeData=32'hDEADBEEF → ready low 5 cycles, then high 1 cycle. SRAM half-word 4=16'hBEEF, 5=16'hDEAD. WE_N low for 4 cycles.
- Load: rdEn=1, address=1032 → after 5 low cycles, readData=32'hDEADBEEF while ready=1. WE_N=1 throughout and sramData never driven by the block.
- Simultaneous rdEn=wrEn=1, address=1024, writeData=32'h12345678 → write performed; half-words 0/1 = 16'h5678/16'h1234; readData unchanged.
- Back-to-back: store then load held across DONE → second access starts the IDLE cycle after DONE; total 12 cycles for the pair. Inputs changed mid-access are ignored.
- Reset mid-access: assert rst=0 during HI of a load → immediate IDLE, sramCtrl=5'b11111, readData=0. With SRAM_STALL_CNT_EN, stallCount=0 after reset and equals 5 after one subsequent access.
